// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button indices, the button payload struct and the
// responder FSM state encoding (also used by nes_controller).
package nes_pkg;

   localparam int unsigned NES_FRAME_BITS = 8;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   // Bit order matches the wire order: btn_a is shifted out first.
   typedef struct packed {
      logic btn_right;
      logic btn_left;
      logic btn_down;
      logic btn_up;
      logic btn_start;
      logic btn_select;
      logic btn_b;
      logic btn_a;
   } nes_buttons_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } nes_resp_state_t;

endpackage

// File: rtl/nes_edge_sync.sv
// Multi-flop synchronizer for an asynchronous host line, followed by a rise detector.
module nes_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise_c
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level  = r_sync[SYNC_STAGES-1];
   assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/nes_pad_responder.sv
// Device side of the NES pad link (4021 behaviour): shifts a button vector out on host pulses.
// Optional turbo auto-fire is built only when NES_TURBO_EN is defined.
module nes_pad_responder
   import nes_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned TURBO_PERIOD   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nes_latch,
   input  logic       nes_clock,
   input  logic [7:0] buttons,
   input  logic [7:0] turbo_mask,
   output logic       nes_data,
   output logic       busy,
   output logic [3:0] bit_index,
   output logic       frame_done
);

   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned BIT_W = 4;

   logic w_latch_lvl, w_unused_latch_rise_c;
   logic w_unused_clk_lvl, w_clk_rise_c;

   nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
      .clk      (clk),
      .reset    (reset),
      .i_async  (nes_latch),
      .o_level  (w_latch_lvl),
      .o_rise_c (w_unused_latch_rise_c)
   );

   nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clock (
      .clk      (clk),
      .reset    (reset),
      .i_async  (nes_clock),
      .o_level  (w_unused_clk_lvl),
      .o_rise_c (w_clk_rise_c)
   );

   nes_resp_state_t r_state, w_state_n;
   logic [NES_FRAME_BITS-1:0] r_shift, w_shift_n;
   logic [BIT_W-1:0]          w_bit_n;
   logic [TO_W-1:0]           r_to_cnt, w_to_n;
   logic                      w_data_n, w_busy_n, w_done_n;
   nes_buttons_t              w_load;

`ifdef NES_TURBO_EN
   logic [7:0] r_frame_cnt;
   logic [7:0] w_cur_frame;
   logic [7:0] w_turbo_quot;
   logic       w_phase;

   // The counter already advanced on LOAD entry, so step back while still loading.
   assign w_cur_frame  = (r_state == ST_LOAD) ? r_frame_cnt - 8'd1 : r_frame_cnt;
   assign w_turbo_quot = w_cur_frame / 8'(TURBO_PERIOD);
   assign w_phase      = w_turbo_quot[0];
   assign w_load       = nes_buttons_t'(~(buttons & ~(turbo_mask & {8{w_phase}})));

   always_ff @(posedge clk) begin
      if (reset)
         r_frame_cnt <= 8'd0;
      else if (w_latch_lvl && (r_state != ST_LOAD))
         r_frame_cnt <= r_frame_cnt + 8'd1;
   end
`else
   logic w_unused_turbo;
   assign w_unused_turbo = ^turbo_mask;
   assign w_load         = nes_buttons_t'(~buttons);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= 8'hFF;
         r_to_cnt   <= '0;
         nes_data   <= 1'b1;
         busy       <= 1'b0;
         bit_index  <= '0;
         frame_done <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_shift    <= w_shift_n;
         r_to_cnt   <= w_to_n;
         nes_data   <= w_data_n;
         busy       <= w_busy_n;
         bit_index  <= w_bit_n;
         frame_done <= w_done_n;
      end
   end

   // Latch has priority over everything, including a coincident clock rise.
   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_bit_n   = bit_index;
      w_data_n  = nes_data;
      w_busy_n  = busy;
      w_done_n  = 1'b0;
      w_to_n    = r_to_cnt;
      if (w_latch_lvl) begin
         w_state_n = ST_LOAD;
         w_shift_n = w_load;
         w_data_n  = w_load.btn_a;
         w_bit_n   = '0;
         w_busy_n  = 1'b1;
         w_to_n    = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_shift_n = 8'hFF;
               w_data_n  = 1'b1;
               w_busy_n  = 1'b0;
               w_bit_n   = '0;
               w_to_n    = '0;
            end
            ST_LOAD: begin
               w_state_n = ST_SHIFT;
               w_to_n    = '0;
            end
            ST_SHIFT: begin
               if (w_clk_rise_c) begin
                  w_shift_n = {1'b1, r_shift[NES_FRAME_BITS-1:1]};
                  w_to_n    = '0;
                  if (bit_index == BIT_W'(NES_FRAME_BITS - 1)) begin
                     w_state_n = ST_DONE;
                     w_bit_n   = BIT_W'(NES_FRAME_BITS);
                     w_done_n  = 1'b1;
                     w_data_n  = 1'b1;
                     w_busy_n  = 1'b0;
                  end else begin
                     w_bit_n  = bit_index + BIT_W'(1);
                     w_data_n = r_shift[1];
                  end
               end else if (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1)) begin
                  w_state_n = ST_IDLE;
                  w_shift_n = 8'hFF;
                  w_data_n  = 1'b1;
                  w_busy_n  = 1'b0;
                  w_bit_n   = '0;
                  w_to_n    = '0;
               end else begin
                  w_to_n = r_to_cnt + TO_W'(1);
               end
            end
            ST_DONE: begin
               w_data_n = 1'b1;
               w_busy_n = 1'b0;
            end
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: expected bits are queued by the host driver
// and popped by a monitor at every host clock rise.
module tb_nes_pad_responder;

   localparam int unsigned SYNC = 2;
   localparam int unsigned TO   = 200;
   localparam int unsigned TP   = 4;
   localparam int          PH   = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       nes_latch = 1'b0;
   logic       nes_clock = 1'b0;
   logic [7:0] buttons = 8'h00;
   logic [7:0] turbo_mask = 8'h00;
   logic       nes_data;
   logic       busy;
   logic [3:0] bit_index;
   logic       frame_done;

   int   n_vec = 0;
   int   n_err = 0;
   int   fd_count = 0;
   logic q_bits[$];
   logic mon_exp;

   always #5 clk = ~clk;

   nes_pad_responder #(
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TO),
      .TURBO_PERIOD   (TP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .nes_latch  (nes_latch),
      .nes_clock  (nes_clock),
      .buttons    (buttons),
      .turbo_mask (turbo_mask),
      .nes_data   (nes_data),
      .busy       (busy),
      .bit_index  (bit_index),
      .frame_done (frame_done)
   );

   // Host reads the data line just as it raises nes_clock.
   always @(posedge nes_clock) begin
      n_vec++;
      if (q_bits.size() == 0) begin
         n_err++;
         $display("FAIL bit_read: got %b, no expected bit queued", nes_data);
      end else begin
         mon_exp = q_bits.pop_front();
         if (nes_data !== mon_exp) begin
            n_err++;
            $display("FAIL bit_read: got %b, expected %b", nes_data, mon_exp);
         end
      end
   end

   always @(negedge clk)
      if (frame_done === 1'b1) fd_count++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic latch_pulse();
      @(negedge clk);
      nes_latch = 1'b1;
      wait_clks(PH);
      nes_latch = 1'b0;
      wait_clks(PH);
   endtask

   task automatic clock_pulse(input logic exp_bit);
      q_bits.push_back(exp_bit);
      nes_clock = 1'b1;
      wait_clks(PH);
      nes_clock = 1'b0;
      wait_clks(PH);
   endtask

   // Pulses n host clocks; reads 1..8 expect the hand-computed vector LSB first, then 1s.
   task automatic pulses(input logic [7:0] exp_bits, input int n);
      logic [7:0] v;
      v = exp_bits;
      for (int i = 0; i < n; i++)
         clock_pulse((i < 8) ? v[i] : 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fd0;

      // 1: reset
      wait_clks(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_nes_data", 32'(nes_data), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_bit_index", 32'(bit_index), 0);
      check("rst_frame_done", 32'(frame_done), 0);

      // 2: A+Start; buttons changed after latch must not affect the frame
      fd0 = fd_count;
      buttons = 8'h09;
      latch_pulse();
      check("t2_busy_loaded", 32'(busy), 1);
      check("t2_bit0_on_line", 32'(nes_data), 0);
      buttons = 8'hFF;
      pulses(8'b1111_0110, 8);
      check("t2_frame_done_cycles", 32'(fd_count - fd0), 1);
      check("t2_data_after", 32'(nes_data), 1);
      check("t2_busy_after", 32'(busy), 0);
      check("t2_bit_index_after", 32'(bit_index), 8);

      // 3: overrun past the 8th bit
      fd0 = fd_count;
      buttons = 8'h5A;
      latch_pulse();
      pulses(8'b1010_0101, 10);
      check("t3_bit_index_stuck", 32'(bit_index), 8);
      check("t3_single_done", 32'(fd_count - fd0), 1);

      // 4: latch reasserted mid-frame
      fd0 = fd_count;
      buttons = 8'h09;
      latch_pulse();
      pulses(8'b1111_0110, 3);
      check("t4_bit_index_mid", 32'(bit_index), 3);
      buttons = 8'h80;
      latch_pulse();
      check("t4_reload_data", 32'(nes_data), 1);
      check("t4_reload_index", 32'(bit_index), 0);
      check("t4_reload_busy", 32'(busy), 1);
      pulses(8'b0111_1111, 8);
      check("t4_one_done", 32'(fd_count - fd0), 1);

      // 5: host stalls mid-frame
      fd0 = fd_count;
      buttons = 8'h00;
      latch_pulse();
      pulses(8'hFF, 2);
      check("t5_busy_before_to", 32'(busy), 1);
      wait_clks(TO + 1);
      check("t5_busy_after_to", 32'(busy), 0);
      check("t5_data_after_to", 32'(nes_data), 1);
      check("t5_no_done", 32'(fd_count - fd0), 0);

      // 7: reset mid-frame
      buttons = 8'h04;
      latch_pulse();
      pulses(8'b1111_1011, 2);
      check("t7_data_select", 32'(nes_data), 0);
      reset = 1'b1;
      @(negedge clk);
      check("t7_rst_data", 32'(nes_data), 1);
      check("t7_rst_busy", 32'(busy), 0);
      check("t7_rst_index", 32'(bit_index), 0);
      check("t7_rst_done", 32'(frame_done), 0);
      reset = 1'b0;
      wait_clks(4);

`ifdef NES_TURBO_EN
      // 6: turbo on A, fresh frame counter
      reset = 1'b1;
      wait_clks(2);
      reset = 1'b0;
      wait_clks(2);
      fd0 = fd_count;
      buttons    = 8'h01;
      turbo_mask = 8'h01;
      for (int f = 0; f < 8; f++) begin
         latch_pulse();
         pulses((f < 4) ? 8'hFE : 8'hFF, 8);
      end
      check("t6_turbo_frames", 32'(fd_count - fd0), 8);
`endif

      wait_clks(4);
      check("queue_drained", 32'(q_bits.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
